mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register; reads the registered memread/memwrite control, address and store data.
- Performs one data-memory transaction per instruction over a req/gnt/rvalid bus.
- Holds the pipeline via stall_mem until the transaction completes.
- Returns aligned, sign- or zero-extended load data to the MEM/WB register.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before a forced bus-error completion; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- EX_MEM_memread  in  3  0=none, 1=LB, 2=LH, 3=LW, 4=LBU, 5=LHU; 6 and 7 are treated as none
- EX_MEM_memwrite  in  3  0=none, 1=SB, 2=SH, 3=SW; 4..7 are treated as none
- EX_MEM_alu_csr_bujrd_data  in  32  byte address
- EX_MEM_write_data  in  32  store source; the data occupies the low bits
- stall_mem  out  1  combinational; high holds the IF..EX/MEM registers (ORed into stall_CPU)
- dm_req  out  1  request valid
- dm_we  out  1  1=store
- dm_addr  out  32  word address, {addr[31:2],2'b00}
- dm_wstrb  out  4  byte enables; 0 for loads
- dm_wdata  out  32  lane-replicated store data
- dm_gnt  in  1  request accepted this cycle
- dm_rvalid  in  1  response (load data or store ack)
- dm_rdata  in  32  load word
- load_data  out  32  extended load result; registered
- mem_done  out  1  one-cycle pulse on completion
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state=IDLE; timeout counter=0; load_data=0; dm_req=0, dm_we=0, dm_addr=0, dm_wstrb=0, dm_wdata=0; mem_done=0, misalign_err=0, bus_err=0.
- Operation decode:
  - op_valid = (memwrite in 1..3) OR (memread in 1..5).
  - If both fields are valid, the store wins and the read is ignored.
- States:
  - IDLE: if op_valid and aligned, go to REQ. If op_valid and misaligned, go to DONE with the error flag set and no bus request.
  - REQ: dm_req=1 and bus outputs held stable until dm_gnt; on dm_gnt, go to WAIT.
  - WAIT: the counter increments each cycle. On dm_rvalid, capture the extended data and go to DONE. If the counter reaches TIMEOUT, go to DONE with bus_err pending and load_data=0.
  - DONE: mem_done=1 for one cycle, plus the error pulse if one is pending; return to IDLE.
- stall_mem = op_valid AND state!=DONE.
  - In DONE the pipeline advances at the edge, so the same instruction is never re-issued.
  - Back-to-back memory ops restart from IDLE the next cycle.
- Timing rules:
  - dm_rvalid in REQ or IDLE is ignored.
  - dm_gnt and dm_rvalid in the same cycle: the gnt is honoured and the rvalid is dropped. The bus guarantees rvalid at least 1 cycle after gnt.
- Latency with a zero-wait bus (gnt in REQ, rvalid the next cycle): op seen at cycle 0 → REQ at 1, WAIT at 2, DONE at 3. stall_mem is high in cycles 0..2.
- Misalignment:
  - LH, LHU, SH: fault when addr[0]=1.
  - LW, SW: fault when addr[1:0]!=0.
  - On a fault, load_data=0 and the destination register write still occurs.
- Stores:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata={4{wd[7:0]}}.
  - SH: wstrb=4'b0011<<addr[1:0]; wdata={2{wd[15:0]}}.
  - SW: wstrb=4'hF; wdata=wd.
- Loads:
  - byte = rdata[8*addr[1:0] +: 8].
  - half = rdata[16*addr[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- load_data holds its value until the next load completion or error completion.
- Counter: 8 bits, cleared on entering WAIT.
- Asynchronous reset mid-transaction: immediately returns to IDLE with dm_req=0. A later stale dm_rvalid is ignored.

Test Plan:
1. LW at addr 0x100; bus gnt at cycle 1, rvalid at cycle 2 with rdata=0xDEADBEEF → dm_addr=0x100; stall_mem high for cycles 0-2; load_data=0xDEADBEEF with mem_done at cycle 3.
2. LB at 0x103 and LBU at 0x103, rdata=0x80FF1234 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
3. SB at 0x201, wd=0x000000A5 → dm_we=1, dm_addr=0x200, dm_wstrb=0010, dm_wdata=0xA5A5A5A5. SH at 0x202 gives dm_wstrb=1100.
4. LW at 0x102 → no dm_req; misalign_err and mem_done pulse at cycle 1; load_data=0; stall high only in cycle 0.
5. TIMEOUT=4, gnt given but rvalid never arrives → after 4 WAIT cycles, bus_err and mem_done pulse; load_data=0; FSM returns to IDLE.
6. rst pulsed while in WAIT, then rvalid arrives → dm_req=0, no mem_done, load_data stays 0. Back-to-back SW then LW completes both operations with no dropped cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: req/gnt request phase followed by an rvalid response phase.
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one bus transaction per instruction, stalls the pipe
// until completion and returns aligned, extended load data.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         EX_MEM_memread,
  input  logic [2:0]         EX_MEM_memwrite,
  input  logic [31:0]        EX_MEM_alu_csr_bujrd_data,
  input  logic [31:0]        EX_MEM_write_data,
  output logic               stall_mem,
  mem_access_unit_if.master  dm,
  output logic [31:0]        load_data,
  output logic               mem_done,
  output logic               misalign_err,
  output logic               bus_err
);

  // IDLE decode op | REQ hold bus until gnt | WAIT await rvalid or timeout | DONE completion pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic        merr_q, merr_d;
  logic        berr_q, berr_d;

  logic        wr_ok, rd_ok, op_valid, misal;
  logic [1:0]  a_lo;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  assign a_lo     = EX_MEM_alu_csr_bujrd_data[1:0];
  assign wr_ok    = EX_MEM_memwrite inside {[3'd1:3'd3]};
  assign rd_ok    = EX_MEM_memread inside {[3'd1:3'd5]};
  assign op_valid = wr_ok | rd_ok;

  // A valid store takes precedence over a simultaneously valid load
  always_comb begin
    misal     = 1'b0;
    wstrb_new = 4'b0000;
    wdata_new = '0;
    if (wr_ok) begin
      case (EX_MEM_memwrite)
        3'd1: begin
          wstrb_new = 4'b0001 << a_lo;
          wdata_new = {4{EX_MEM_write_data[7:0]}};
        end
        3'd2: begin
          misal     = a_lo[0];
          wstrb_new = 4'b0011 << a_lo;
          wdata_new = {2{EX_MEM_write_data[15:0]}};
        end
        default: begin
          misal     = (a_lo != 2'b00);
          wstrb_new = 4'hF;
          wdata_new = EX_MEM_write_data;
        end
      endcase
    end else begin
      case (EX_MEM_memread)
        3'd2, 3'd5: misal = a_lo[0];
        3'd3:       misal = (a_lo != 2'b00);
        default:    misal = 1'b0;
      endcase
    end
  end

  always_comb begin
    byte_sel = dm.dm_rdata[{lane_q, 3'b000} +: 8];
    half_sel = dm.dm_rdata[{lane_q[1], 4'b0000} +: 16];
    case (op_q)
      3'd1:    ext = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    ext = {{16{half_sel[15]}}, half_sel};
      3'd4:    ext = {24'b0, byte_sel};
      3'd5:    ext = {16'b0, half_sel};
      default: ext = dm.dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    lane_d  = lane_q;
    merr_d  = merr_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          merr_d = 1'b0;
          berr_d = 1'b0;
          if (misal) begin
            merr_d  = 1'b1;
            load_d  = '0;
            state_d = S_DONE;
          end else begin
            we_d    = wr_ok;
            addr_d  = {EX_MEM_alu_csr_bujrd_data[31:2], 2'b00};
            wstrb_d = wstrb_new;
            wdata_d = wdata_new;
            op_d    = EX_MEM_memread;
            lane_d  = a_lo;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // an rvalid coinciding with gnt belongs to no request of ours and is dropped
        if (dm.dm_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dm.dm_rvalid) begin
          if (!we_q) load_d = ext;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          berr_d  = 1'b1;
          load_d  = '0;
          state_d = S_DONE;
        end
      end
      default: begin
        merr_d  = 1'b0;
        berr_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      merr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      merr_q  <= merr_d;
      berr_q  <= berr_d;
    end
  end

  // Releasing the stall in DONE lets the pipeline advance past this instruction
  assign stall_mem    = op_valid && (state_q != S_DONE);
  assign dm.dm_req    = (state_q == S_REQ);
  assign dm.dm_we     = we_q;
  assign dm.dm_addr   = addr_q;
  assign dm.dm_wstrb  = wstrb_q;
  assign dm.dm_wdata  = wdata_q;
  assign load_data    = load_q;
  assign mem_done     = (state_q == S_DONE);
  assign misalign_err = (state_q == S_DONE) && merr_q;
  assign bus_err      = (state_q == S_DONE) && berr_q;

endmodule
